// File: rtl/spi_controller.sv
// SPI master that issues 16-bit register frames: a {rw, pad, addr} header byte, then one data byte.
// Every SPI pin is driven from a flop; a low ena freezes the whole block in place.
module spi_controller #(
    parameter int CLK_DIV    = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int REG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  start,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [REG_WIDTH-1:0]  wdata,
    input  logic [1:0]            mode,
    output logic                  busy,
    output logic                  done,
    output logic [REG_WIDTH-1:0]  rdata,
    output logic                  spi_cs_n,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);
    localparam int FRAME_BITS = 8 + REG_WIDTH;
    localparam int NUM_HALF   = 2 * FRAME_BITS;
    localparam int HW         = $clog2(NUM_HALF);
    localparam logic [7:0]    H_LAST    = 8'(CLK_DIV - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(NUM_HALF - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [7:0]            hcnt_q, hcnt_d;
    logic [HW-1:0]         half_q, half_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [REG_WIDTH-1:0]  rx_q, rx_d;
    logic [REG_WIDTH-1:0]  rdata_q, rdata_d;
    logic                  cpha_q, cpha_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  hc_last_s;
    logic                  edge_s;
    logic [HW-1:0]         edge_idx_s;

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic                  rw_i,
        input logic [ADDR_WIDTH-1:0] addr_i,
        input logic [REG_WIDTH-1:0]  data_i
    );
        logic [7:0]           hdr;
        logic [REG_WIDTH-1:0] body;
        hdr                   = 8'h00;
        hdr[ADDR_WIDTH-1:0]   = addr_i;
        hdr[7]                = rw_i;
        body                  = rw_i ? data_i : {REG_WIDTH{1'b0}};
        return {hdr, body};
    endfunction

    // SPI clock edges: one on leaving SETUP, one at the end of every SHIFT half-period but the last.
    always_comb begin
        hc_last_s  = (hcnt_q == H_LAST);
        edge_s     = 1'b0;
        edge_idx_s = '0;
        case (state_q)
            ST_SETUP: begin
                edge_s     = hc_last_s;
                edge_idx_s = '0;
            end
            ST_SHIFT: begin
                edge_s     = hc_last_s && (half_q != HALF_LAST);
                edge_idx_s = half_q + HW'(1);
            end
            default: begin
                edge_s     = 1'b0;
                edge_idx_s = '0;
            end
        endcase
    end

    // Next-state and next-output computation; everything holds while ena is low.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        half_d  = half_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        cpha_d  = cpha_q;
        busy_d  = busy_q;
        done_d  = done_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        if (ena) begin
            done_d = 1'b0;
            hcnt_d = hc_last_s ? 8'h00 : hcnt_q + 8'h01;
            // Even edge indices are leading edges; the sample edge type is selected by cpha.
            if (edge_s) begin
                sclk_d = ~sclk_q;
                if (edge_idx_s[0] == cpha_q) begin
                    rx_d = {rx_q[REG_WIDTH-2:0], spi_miso};
                end else if ((edge_idx_s != '0) && (edge_idx_s != HALF_LAST)) begin
                    tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
                    mosi_d = tx_q[FRAME_BITS-2];
                end else begin
                    tx_d = tx_q;
                end
            end else begin
                sclk_d = sclk_q;
            end
            case (state_q)
                ST_IDLE: begin
                    hcnt_d = 8'h00;
                    half_d = '0;
                    cs_n_d = 1'b1;
                    mosi_d = 1'b0;
                    sclk_d = mode[1];
                    busy_d = 1'b0;
                    if (start) begin
                        state_d = ST_SETUP;
                        busy_d  = 1'b1;
                        cs_n_d  = 1'b0;
                        cpha_d  = mode[0];
                        tx_d    = build_frame(rw, addr, wdata);
                        mosi_d  = tx_d[FRAME_BITS-1];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SETUP: state_d = hc_last_s ? ST_SHIFT : ST_SETUP;
                ST_SHIFT: begin
                    if (hc_last_s) begin
                        if (half_q == HALF_LAST) begin
                            state_d = ST_HOLD;
                            half_d  = '0;
                        end else begin
                            state_d = ST_SHIFT;
                            half_d  = half_q + HW'(1);
                        end
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_HOLD: begin
                    if (hc_last_s) begin
                        state_d = ST_GAP;
                        cs_n_d  = 1'b1;
                        done_d  = 1'b1;
                        rdata_d = rx_q;
                        mosi_d  = 1'b0;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_GAP: begin
                    if (hc_last_s) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hcnt_q  <= 8'h00;
            half_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            cpha_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            half_q  <= half_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            cpha_q  <= cpha_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign spi_cs_n = cs_n_q;
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;

endmodule
